ps2_scan_ctrl: RTL
==================

// Module: ps2_scan_ctrl
// PURPOSE
//  Sequences the PS/2 receiver's scan_ready/read handshake from the clk_100 domain. Captures each
//  scan byte and folds E0/F0 prefixes into key events {ext,brk,code}. Queues events in a small FWFT FIFO
//  for the CPU bus wrapper, so software never drives the receiver's read line directly.
// PARAMETERS
//  FIFO_DEPTH      8       event FIFO entries, power of two, >=2
//  READ_PULSE      4       minimum clk_100 cycles read_o is held high per byte
//  ACK_TIMEOUT     1024    max cycles in ACK waiting for scan_ready to fall before error
//  PREFIX_TIMEOUT  2000000 cycles a pending prefix survives without a following byte (20 ms)
// PORTS
//  clk_100        in   1   system clock, 100 MHz
//  reset          in   1   synchronous, active-high
//  scan_ready_i   in   1   receiver byte-available flag, asynchronous to clk_100
//  scan_code_i    in   8   receiver byte, stable while scan_ready_i high
//  read_o         out  1   to receiver read; high clears scan_ready_i
//  evt_valid      out  1   FIFO non-empty
//  evt_data       out  10  head event {ext, brk, code[7:0]}, valid when evt_valid
//  evt_pop        in   1   remove head event; ignored when evt_valid=0
//  evt_count      out  log2(FIFO_DEPTH)+1  events queued
//  overflow       out  1   sticky: event dropped because FIFO full
//  ack_err        out  1   sticky: ACK_TIMEOUT expired
//  rx_err         out  1   sticky: receiver delivered 0x00 or 0xFF
//  clear_err      in   1   clears overflow, ack_err, rx_err; a set event in the same cycle wins
// BEHAVIOUR
//  Reset: read_o=0, evt_valid=0, evt_count=0, overflow/ack_err/rx_err=0, FIFO emptied,
//   ext/brk prefix flags=0, FSM=IDLE, sync flops=0.
//  scan_ready_i passes through a 2-flop synchronizer -> rdy_s. Only rdy_s is used.
//  FSM:
//   IDLE: if rdy_s=1 -> CAPTURE.
//   CAPTURE: 1 cycle; latch scan_code_i into byte_r; read_o goes high next cycle -> ACK.
//   ACK: read_o=1. Leave when >=READ_PULSE cycles elapsed AND rdy_s=0 -> DECODE, read_o=0.
//    If ACK_TIMEOUT cycles pass with rdy_s=1: set ack_err, read_o=0, drop byte, clear prefixes -> IDLE.
//   DECODE: 1 cycle, then -> IDLE:
//    byte 0xE0 -> ext=1.  byte 0xF0 -> brk=1.
//    byte 0x00/0xFF -> set rx_err, ext=brk=0, nothing pushed.
//    other byte -> push {ext,brk,byte_r}, then ext=brk=0.
//  Prefix timer: runs in IDLE while ext|brk. At PREFIX_TIMEOUT expiry ext=brk=0 silently.
//   Any CAPTURE restarts the timer.
//  Latency: rdy_s=1 -> evt_valid=1 is 2+READ_PULSE+1 cycles minimum, measured CAPTURE..push visible.
//  FIFO: first-word-fall-through. evt_data shows the head combinationally from storage.
//   Pointers wrap modulo FIFO_DEPTH.
//   Pop and push evaluated in the same cycle:
//    full: pop frees a slot, push accepted, count unchanged.
//    empty: pop ignored, push accepted.
//   Push while full with no pop: event dropped, overflow=1.
//  Reset mid-byte (any state): read_o drops next edge, byte abandoned.
//   If the receiver still holds scan_ready_i high after reset, that byte is processed normally.
//  evt_count is exact at all times, 0..FIFO_DEPTH.
// TESTING
//  1. scan_ready_i pulse, code 0x1C -> read_o high >=4 cycles, clears on rdy_s fall; event 0x01C, count=1.
//  2. Bytes E0,F0,0x75 -> single event 0x375. Pop -> evt_valid=0, count=0.
//  3. Byte F0, then idle > PREFIX_TIMEOUT (bench param 100), then 0x1C -> event 0x01C (brk discarded).
//  4. Push 9 codes, no pops -> count=8, overflow=1, head=first code.
//     Full + push + pop same cycle -> count stays 8, overflow unchanged.
//  5. Hold scan_ready_i high through ACK -> ack_err=1 after ACK_TIMEOUT, read_o=0, FSM back to IDLE.
//     Byte 0xFF -> rx_err=1, no event.
//  6. Assert reset during ACK -> read_o=0 and all outputs at reset values next cycle.
//     Byte still pending -> reprocessed after reset drops.

Source files
------------

// File: rtl/ps2_scan_ctrl.sv
// PS/2 receiver handshake sequencer: syncs scan_ready, pulses read, folds E0/F0 prefixes into key events queued in a FWFT FIFO.
// Latency: rdy_s high to event visible is 2 + READ_PULSE + 1 cycles minimum (CAPTURE, ACK >= READ_PULSE, DECODE, push).
// Backpressure: none toward the receiver; a push into a full FIFO without a same-cycle pop drops the event and sets overflow.
module ps2_scan_ctrl #(
    parameter int FIFO_DEPTH     = 8,
    parameter int READ_PULSE     = 4,
    parameter int ACK_TIMEOUT    = 1024,
    parameter int PREFIX_TIMEOUT = 2000000
) (
    input  logic                          clk_100,
    input  logic                          reset,
    input  logic                          scan_ready_i,
    input  logic [7:0]                    scan_code_i,
    output logic                          read_o,
    output logic                          evt_valid,
    output logic [9:0]                    evt_data,
    input  logic                          evt_pop,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          overflow,
    output logic                          ack_err,
    output logic                          rx_err,
    input  logic                          clear_err
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam int ACK_MAX = (ACK_TIMEOUT > READ_PULSE) ? ACK_TIMEOUT : READ_PULSE;
    localparam int ACK_CW  = $clog2(ACK_MAX + 1);
    localparam int PFX_CW  = $clog2(PREFIX_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_ACK     = 2'd2,
        S_DECODE  = 2'd3
    } state_t;

    // synchronizer for the receiver's asynchronous byte-available flag
    logic sync1_q, sync2_q;
    logic rdy_s;

    // sequencer state
    state_t              state_q, state_d;
    logic [7:0]          byte_q, byte_d;
    logic                read_q, read_d;
    logic [ACK_CW-1:0]   ack_cnt_q, ack_cnt_d;
    logic [ACK_CW-1:0]   ack_elapsed;
    logic [PFX_CW-1:0]   pfx_cnt_q, pfx_cnt_d;
    logic                ext_q, ext_d;
    logic                brk_q, brk_d;

    // sticky error flags
    logic                overflow_q, overflow_d;
    logic                ack_err_q, ack_err_d;
    logic                rx_err_q, rx_err_d;

    // event FIFO
    logic [9:0]          mem_q [FIFO_DEPTH];
    logic [9:0]          mem_d [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;

    // decode-side requests into the FIFO and flag logic
    logic                push_req;
    logic [9:0]          push_dat;
    logic                set_rx_err;
    logic                set_ack_err;
    logic                pop_ok;
    logic                push_ok;
    logic                drop_evt;

    assign rdy_s = sync2_q;

    // two-flop synchronizer; only rdy_s is ever looked at downstream
    always_ff @(posedge clk_100) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= scan_ready_i;
            sync2_q <= sync1_q;
        end
    end

    // cycles spent in ACK including the current one
    assign ack_elapsed = ack_cnt_q + ACK_CW'(1);

    // handshake FSM, prefix folding and prefix expiry timer
    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        ack_cnt_d   = ack_cnt_q;
        pfx_cnt_d   = pfx_cnt_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        push_req    = 1'b0;
        push_dat    = 10'd0;
        set_rx_err  = 1'b0;
        set_ack_err = 1'b0;

        case (state_q)
            S_IDLE: begin
                // a pending prefix only survives a bounded quiet period
                if (ext_q || brk_q) begin
                    if (pfx_cnt_q == PFX_CW'(PREFIX_TIMEOUT - 1)) begin
                        ext_d     = 1'b0;
                        brk_d     = 1'b0;
                        pfx_cnt_d = '0;
                    end else begin
                        pfx_cnt_d = pfx_cnt_q + PFX_CW'(1);
                    end
                end else begin
                    pfx_cnt_d = '0;
                end
                if (rdy_s) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                byte_d    = scan_code_i;
                ack_cnt_d = '0;
                pfx_cnt_d = '0;
                state_d   = S_ACK;
            end
            S_ACK: begin
                if ((ack_elapsed >= ACK_CW'(READ_PULSE)) && !rdy_s) begin
                    state_d = S_DECODE;
                end else if (rdy_s && (ack_elapsed >= ACK_CW'(ACK_TIMEOUT))) begin
                    // receiver never released the flag: abandon the byte and any prefix
                    set_ack_err = 1'b1;
                    ext_d       = 1'b0;
                    brk_d       = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    ack_cnt_d = ack_elapsed;
                end
            end
            S_DECODE: begin
                state_d = S_IDLE;
                case (byte_q)
                    8'hE0: ext_d = 1'b1;
                    8'hF0: brk_d = 1'b1;
                    8'h00, 8'hFF: begin
                        set_rx_err = 1'b1;
                        ext_d      = 1'b0;
                        brk_d      = 1'b0;
                    end
                    default: begin
                        push_req = 1'b1;
                        push_dat = {ext_q, brk_q, byte_q};
                        ext_d    = 1'b0;
                        brk_d    = 1'b0;
                    end
                endcase
            end
            default: state_d = S_IDLE;
        endcase

        // read is a registered image of being in ACK, so it rises the cycle after CAPTURE
        read_d = (state_d == S_ACK);
    end

    // FIFO accounting: a pop is taken first, so a full FIFO still accepts a push alongside a pop
    always_comb begin
        pop_ok   = evt_pop && (count_q != '0);
        push_ok  = push_req && ((count_q != CW'(FIFO_DEPTH)) || pop_ok);
        drop_evt = push_req && !push_ok;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;

        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // sticky flags: a set in the same cycle as clear_err wins
    always_comb begin
        overflow_d = drop_evt    | (overflow_q & ~clear_err);
        ack_err_d  = set_ack_err | (ack_err_q  & ~clear_err);
        rx_err_d   = set_rx_err  | (rx_err_q   & ~clear_err);
    end

    // control state register; reset abandons any byte in flight
    always_ff @(posedge clk_100) begin
        if (reset) begin
            state_q    <= S_IDLE;
            byte_q     <= 8'd0;
            read_q     <= 1'b0;
            ack_cnt_q  <= '0;
            pfx_cnt_q  <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            overflow_q <= 1'b0;
            ack_err_q  <= 1'b0;
            rx_err_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            read_q     <= read_d;
            ack_cnt_q  <= ack_cnt_d;
            pfx_cnt_q  <= pfx_cnt_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            overflow_q <= overflow_d;
            ack_err_q  <= ack_err_d;
            rx_err_q   <= rx_err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // event storage needs no reset: an empty FIFO never exposes its contents as valid
    always_ff @(posedge clk_100) begin
        mem_q <= mem_d;
    end

    assign read_o    = read_q;
    assign evt_valid = (count_q != '0);
    assign evt_data  = mem_q[rd_ptr_q];
    assign evt_count = count_q;
    assign overflow  = overflow_q;
    assign ack_err   = ack_err_q;
    assign rx_err    = rx_err_q;

endmodule
